array2string: RTL and testbench

ARRAY2STRING -- requirements
Module: array2string

---
 rtl/sha3_pkg.sv | 38 +++
 rtl/array2string.sv | 134 +++++++++++++
 tb/tb_array2string.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sha3_pkg.sv
// sha3_pkg: shared geometry, state/string types and the array->string flatten used by the sha3 blocks.
// Revision: 1.0
`default_nettype none

package sha3_pkg;

  localparam int X      = 5;
  localparam int Y      = 5;
  localparam int Z      = 64;
  localparam int BEAT_W = 200;
  localparam int NBEATS = 8;
  localparam int STR_W  = X * Y * Z;

  typedef logic [X-1:0][Y-1:0][Z-1:0] state_t;
  typedef logic [STR_W-1:0]           string_t;

  typedef enum logic [0:0] {
    A2S_IDLE = 1'b0,
    A2S_SEND = 1'b1
  } a2s_state_e;

  // Lane (x,y) lands at string offset Z*(Y*y+x): y-major ordering of lanes.
  function automatic string_t flatten(input state_t a);
    string_t s;
    s = '0;
    for (int x = 0; x < X; x++) begin
      for (int y = 0; y < Y; y++) begin
        for (int z = 0; z < Z; z++) begin
          s[Z*(Y*y+x)+z] = a[x][y][z];
        end
      end
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/array2string.sv
// array2string: serializes a captured sha3 state into NBEATS beats of BEAT_W bits with backpressure.
// Optional macro A2S_DBUF_EN adds a second holding buffer. Revision: 1.0
`default_nettype none

module array2string #(
  parameter int X      = sha3_pkg::X,
  parameter int Y      = sha3_pkg::Y,
  parameter int Z      = sha3_pkg::Z,
  parameter int BEAT_W = sha3_pkg::BEAT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pushin,
  input  logic [X-1:0][Y-1:0][Z-1:0] A,
  input  logic                       stopin,
  output logic                       pushout,
  output logic [2:0]                 dix,
  output logic [BEAT_W-1:0]          dout,
  output logic                       busy
);

  import sha3_pkg::*;

  localparam logic [2:0] LAST_BEAT = 3'(NBEATS - 1);

  a2s_state_e state_q, state_d;
  logic [2:0] dix_q, dix_d;
  string_t    ser_q, ser_d;
  string_t    flat_in;
  logic       consume;
  logic       last_beat;
  logic       accept;

  assign flat_in   = flatten(A);
  assign consume   = (state_q == A2S_SEND) && !stopin;
  assign last_beat = consume && (dix_q == LAST_BEAT);

`ifdef A2S_DBUF_EN
  string_t hold_q, hold_d;
  logic    hold_vld_q, hold_vld_d;

  // Holding buffer only fills while sending, so a full hold implies SEND.
  assign busy = hold_vld_q && !last_beat;
`else
  assign busy = (state_q == A2S_SEND) && !last_beat;
`endif

  assign accept = pushin && !busy;

  always_comb begin
    state_d = state_q;
    dix_d   = dix_q;
    ser_d   = ser_q;
`ifdef A2S_DBUF_EN
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
`endif
    case (state_q)
      A2S_IDLE: begin
        if (accept) begin
          ser_d   = flat_in;
          dix_d   = 3'd0;
          state_d = A2S_SEND;
        end
      end
      A2S_SEND: begin
        if (consume) begin
          dix_d = dix_q + 3'd1;
        end
`ifdef A2S_DBUF_EN
        if (last_beat) begin
          if (hold_vld_q) begin
            ser_d      = hold_q;
            hold_vld_d = accept;
            if (accept) begin
              hold_d = flat_in;
            end
          end else if (accept) begin
            ser_d = flat_in;
          end else begin
            state_d = A2S_IDLE;
          end
        end else if (accept) begin
          hold_d     = flat_in;
          hold_vld_d = 1'b1;
        end
`else
        // Back-to-back frame: reload on the last beat so beat 0 follows with no bubble.
        if (last_beat) begin
          if (accept) begin
            ser_d = flat_in;
          end else begin
            state_d = A2S_IDLE;
          end
        end
`endif
      end
      default: begin
        state_d = A2S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= A2S_IDLE;
      dix_q   <= 3'd0;
      ser_q   <= '0;
    end else begin
      state_q <= state_d;
      dix_q   <= dix_d;
      ser_q   <= ser_d;
    end
  end

`ifdef A2S_DBUF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end
`endif

  assign pushout = (state_q == A2S_SEND);
  assign dix     = dix_q;
  assign dout    = pushout ? ser_q[dix_q*BEAT_W +: BEAT_W] : '0;

endmodule

`default_nettype wire

// File: tb/tb_array2string.sv
// tb_array2string: randomized and directed checks of array2string against a frame-queue reference model.
// Revision: 1.0
`default_nettype none

module tb_array2string;
  import sha3_pkg::*;

`ifdef A2S_DBUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         pushin;
  logic         stopin;
  state_t       A;
  logic         pushout;
  logic [2:0]   dix;
  logic [199:0] dout;
  logic         busy;

  array2string dut (
    .clk    (clk),
    .reset  (reset),
    .pushin (pushin),
    .A      (A),
    .stopin (stopin),
    .pushout(pushout),
    .dix    (dix),
    .dout   (dout),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of pending frame strings plus the beat position of the head frame.
  logic [1599:0] mq[$];
  state_t        aq[$];
  int            mbeat      = 0;
  int            accepted   = 0;
  int            frames_out = 0;
  int            po_cnt     = 0;
  logic [1599:0] rx         = '0;
  logic [199:0]  seen_dout;

  task automatic check(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1599:0] ref_string(input state_t a);
    logic [1599:0] s;
    s = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        for (int z = 0; z < 64; z++)
          s[64*(5*y+x)+z] = a[x][y][z];
    return s;
  endfunction

  function automatic state_t ref_unflatten(input logic [1599:0] s);
    state_t a;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        for (int z = 0; z < 64; z++)
          a[x][y][z] = s[64*(5*y+x)+z];
    return a;
  endfunction

  function automatic state_t rand_state();
    logic [1599:0] v;
    for (int i = 0; i < 50; i++) v[i*32 +: 32] = $urandom;
    return state_t'(v);
  endfunction

  task automatic step(input logic pin, input state_t a, input logic sin);
    logic cons;
    logic exp_busy;
    @(negedge clk);
    pushin = pin;
    A      = a;
    stopin = sin;
    #1;
    cons     = (mq.size() > 0) && !sin;
    exp_busy = (mq.size() == CAP) && !(cons && mbeat == 7);
    seen_dout = dout;
    check("pushout", pushout, mq.size() > 0);
    check("busy", busy, exp_busy);
    if (mq.size() > 0) begin
      check("dix", dix, mbeat);
      check("dout", dout, mq[0][200*mbeat +: 200]);
    end
    if (pushout) po_cnt++;
    if (pushout && !sin) begin
      rx[200*dix +: 200] = dout;
      if (dix == 3'd7) begin
        frames_out++;
        if (aq.size() > 0) check("frame", ref_unflatten(rx), aq.pop_front());
        else               check("frame_extra", pushout, 1'b0);
      end
    end
    if (cons) begin
      mbeat++;
      if (mbeat == 8) begin
        mbeat = 0;
        void'(mq.pop_front());
      end
    end
    if (pin && !exp_busy) begin
      mq.push_back(ref_string(a));
      aq.push_back(a);
      accepted++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, rand_state(), 1'b0);
  endtask

  state_t pat;
  int     base;
  int     cyc;

  initial begin
    reset  = 1'b1;
    pushin = 1'b0;
    stopin = 1'b0;
    A      = '0;
    #2;
    check("rst_pushout", pushout, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_dix", dix, 3'd0);
    check("rst_dout", dout, 200'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Lane (x,y) carries {x,y} in its low byte.
    pat = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        pat[x][y][7:0] = 8'((x << 4) | y);
    po_cnt = 0;
    step(1'b1, pat, 1'b0);
    step(1'b0, pat, 1'b0);
    check("beat0_lane00", seen_dout[63:0], 64'h00);
    check("beat0_lane10", seen_dout[127:64], 64'h10);
    idle(10);
    check("single_po_cycles", po_cnt, 8);

    // Stall with stopin while dix=3 is shown.
    po_cnt = 0;
    step(1'b1, rand_state(), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, rand_state(), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, rand_state(), 1'b1);
    idle(8);
    check("stall_po_cycles", po_cnt, 12);

    // stopin in IDLE is inert.
    for (int i = 0; i < 3; i++) step(1'b0, rand_state(), 1'b1);

    // New frame accepted on the cycle beat 7 is consumed.
    po_cnt = 0;
    step(1'b1, rand_state(), 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, rand_state(), 1'b0);
    step(1'b1, rand_state(), 1'b0);
    idle(10);
    check("b2b_po_cycles", po_cnt, 16);

    // Three consecutive pushins.
    base = frames_out;
    for (int i = 0; i < 3; i++) step(1'b1, rand_state(), 1'b0);
    idle(24);
    check("burst_frames", frames_out - base, CAP);

    // Asynchronous reset while dix=4 is on the bus.
    step(1'b1, rand_state(), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, rand_state(), 1'b0);
    @(negedge clk);
    check("pre_rst_dix", dix, 3'd4);
    reset = 1'b1;
    #1;
    check("arst_pushout", pushout, 1'b0);
    check("arst_dix", dix, 3'd0);
    check("arst_dout", dout, 200'd0);
    check("arst_busy", busy, 1'b0);
    mq.delete();
    aq.delete();
    mbeat = 0;
    @(negedge clk);
    reset = 1'b0;
    po_cnt = 0;
    idle(12);
    check("post_rst_po_cycles", po_cnt, 0);

    // Randomized traffic until 100 more frames are accepted.
    base = accepted;
    cyc  = 0;
    while ((accepted - base) < 100 && cyc < 6000) begin
      step(($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0, rand_state(),
           ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0);
      cyc++;
    end
    check("rand_accepted", (accepted - base) >= 100, 1'b1);
    idle(40);
    check("drain_empty", aq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
